// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl_pkg.sv - shared FSM encodings, FAIL_VEC none value, uniform vector table
package gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } bist_state_e;

  localparam logic [3:0] FAIL_VEC_NONE = 4'hF;

  // {A2,A1} for uniform vectors 3..0
  localparam logic [7:0] UNI_VEC_TABLE = 8'b11_10_01_00;

  function automatic logic [1:0] uni_vec(input logic [1:0] vi);
    return UNI_VEC_TABLE[{vi, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_vecgen.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_vecgen.sv - maps vector index to A1/A2 buses
// Walking one-hot vectors appended when GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__xor2_bist_vecgen
  import gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl_pkg::*;
#(
  parameter int N_LANES = 8
) (
  input  logic [3:0]         vi_i,
  output logic [N_LANES-1:0] a1_o,
  output logic [N_LANES-1:0] a2_o
);

  logic [1:0] uv;
  assign uv = uni_vec(vi_i[1:0]);

  always_comb begin
    a1_o = '0;
    a2_o = '0;
    if (vi_i < 4'd4) begin
      a1_o = {N_LANES{uv[0]}};
      a2_o = {N_LANES{uv[1]}};
    end
`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN
    else if (vi_i < 4'(4 + N_LANES)) begin
      a1_o = N_LANES'(1) << (vi_i - 4'd4);
    end
`endif
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl.sv - BIST sequencer for a bank of xor2 cells
// Optional walking vectors: GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN.
module gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl
  import gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl_pkg::*;
#(
  parameter int N_LANES       = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT        = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [N_LANES-1:0] A1,
  output logic [N_LANES-1:0] A2,
  input  logic [N_LANES-1:0] Z,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [N_LANES-1:0] ERR_MASK,
  output logic [3:0]         FAIL_VEC
);

`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN
  localparam logic [3:0] NV = 4'(4 + N_LANES);
`else
  localparam logic [3:0] NV = 4'd4;
`endif

  bist_state_e        state_q, state_d;
  logic [3:0]         vi_q, vi_d;
  logic [7:0]         pc_q, pc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [N_LANES-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [N_LANES-1:0] err_q, err_d;
  logic [3:0]         fvec_q, fvec_d;
  logic               pass_q, pass_d;
  logic               busy_q;
  logic [N_LANES-1:0] vec_a1, vec_a2;
  logic [N_LANES-1:0] mism;

  // Compare against what is actually on the bus, not a recomputed vector.
  assign mism = Z ^ (a1_q ^ a2_q);

  gf180mcu_fd_sc_mcu9t5v0__xor2_bist_vecgen #(.N_LANES(N_LANES)) u_vecgen (
    .vi_i (vi_d),
    .a1_o (vec_a1),
    .a2_o (vec_a2)
  );

  always_comb begin
    state_d = state_q;
    vi_d    = vi_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_APPLY;
          err_d   = '0;
          pass_d  = 1'b0;
          fvec_d  = FAIL_VEC_NONE;
          vi_d    = '0;
          pc_d    = '0;
        end
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CHECK: begin
        err_d = err_q | mism;
        if ((mism != '0) && (fvec_q == FAIL_VEC_NONE)) fvec_d = vi_q;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (vi_q == NV - 4'd1) begin
          vi_d = '0;
          pc_d = pc_q + 8'd1;
          if ((pc_q + 8'd1) == 8'(REPEAT)) begin
            state_d = ST_FINISH;
            pass_d  = (err_q == '0);
          end else begin
            state_d = ST_APPLY;
          end
        end else begin
          vi_d    = vi_q + 4'd1;
          state_d = ST_APPLY;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a1_d = '0;
    a2_d = '0;
    if (state_d inside {ST_APPLY, ST_SETTLE, ST_CHECK, ST_NEXT}) begin
      a1_d = vec_a1;
      a2_d = vec_a2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      vi_q    <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      err_q   <= '0;
      fvec_q  <= FAIL_VEC_NONE;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vi_q    <= vi_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign A1       = a1_q;
  assign A2       = a2_q;
  assign BUSY     = busy_q;
  assign DONE     = (state_q == ST_FINISH);
  assign PASS     = pass_q;
  assign ERR_MASK = err_q;
  assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl.sv - scoreboard bench for the xor2 BIST sequencer
module tb_gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl;

`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN
  localparam int NV = 12;
`else
  localparam int NV = 4;
`endif

  typedef struct {
    logic       pass;
    logic [7:0] mask;
    logic [3:0] fvec;
    int         lat;
    int         start_cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0, START3 = 1'b0;
  logic [7:0] A1, A2, Z, A1_3, A2_3, Z3;
  logic       BUSY, DONE, PASS, BUSY3, DONE3, PASS3;
  logic [7:0] EM, EM3;
  logic [3:0] FV, FV3;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0, done3_cnt = 0;
  int   fault_mode = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl #(.N_LANES(8), .SETTLE_CYCLES(2), .REPEAT(1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A1(A1), .A2(A2), .Z(Z),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_MASK(EM), .FAIL_VEC(FV)
  );

  gf180mcu_fd_sc_mcu9t5v0__xor2_bist_ctrl #(.N_LANES(8), .SETTLE_CYCLES(2), .REPEAT(3)) dut_r3 (
    .CLK(CLK), .RST(RST), .START(START3), .A1(A1_3), .A2(A2_3), .Z(Z3),
    .BUSY(BUSY3), .DONE(DONE3), .PASS(PASS3), .ERR_MASK(EM3), .FAIL_VEC(FV3)
  );

  // Lane models: 0 good, 1 lane3 stuck-at-0, 2 lane0 XNOR, 3 lanes 2/5 wired-OR bridge
  always_comb begin
    logic [7:0] g;
    g = A1 ^ A2;
    Z = g;
    case (fault_mode)
      1: Z[3] = 1'b0;
      2: Z[0] = ~g[0];
      3: begin Z[2] = g[2] | g[5]; Z[5] = g[2] | g[5]; end
      default: Z = g;
    endcase
  end
  assign Z3 = (A1_3 ^ A2_3) ^ 8'h01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (DONE) begin
      if (q1.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("pass", PASS, e.pass);
        chk("err_mask", EM, e.mask);
        chk("fail_vec", FV, e.fvec);
        chk("done_latency", cyc - e.start_cyc, e.lat);
      end
      done_cnt++;
    end
    if (DONE3) begin
      if (q3.size() == 0) chk("unexpected_done_r3", 1, 0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("pass_r3", PASS3, e.pass);
        chk("err_mask_r3", EM3, e.mask);
        chk("fail_vec_r3", FV3, e.fvec);
        chk("done_latency_r3", cyc - e.start_cyc, e.lat);
      end
      done3_cnt++;
    end
  end

  task automatic run(input bit r3, input int fault, input logic pass, input logic [7:0] mask,
                     input logic [3:0] fvec, input int lat, input bit restart);
    exp_t e;
    int   base;
    bit   seen;
    fault_mode = fault;
    base = r3 ? done3_cnt : done_cnt;
    @(negedge CLK);
    if (r3) START3 = 1'b1; else START = 1'b1;
    e.pass = pass; e.mask = mask; e.fvec = fvec; e.lat = lat; e.start_cyc = cyc;
    if (r3) q3.push_back(e); else q1.push_back(e);
    @(negedge CLK);
    START = 1'b0; START3 = 1'b0;
    chk("busy_rise", r3 ? BUSY3 : BUSY, 1);
    if (restart) begin
      repeat (5) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      #1;
      seen = ((r3 ? done3_cnt : done_cnt) != base);
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    chk("rst_a1", A1, 0);
    chk("rst_a2", A2, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pass", PASS, 0);
    chk("rst_mask", EM, 0);
    chk("rst_fvec", FV, 4'hF);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run(0, 0, 1'b1, 8'h00, 4'hF, 1 + NV * 5, 0);
    run(0, 1, 1'b0, 8'h08, 4'h1, 1 + NV * 5, 0);
    run(0, 2, 1'b0, 8'h01, 4'h0, 1 + NV * 5, 0);
    run(1, 0, 1'b0, 8'h01, 4'h0, 1 + 3 * NV * 5, 0);

    // Abort in SETTLE of vector 2 after lane3 has already failed on vector 1
    fault_mode = 1;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (11) @(negedge CLK);
    chk("pre_abort_mask", EM, 8'h08);
    chk("pre_abort_busy", BUSY, 1);
    RST = 1'b1;
    #1;
    chk("abort_a1", A1, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_mask", EM, 0);
    chk("abort_fvec", FV, 4'hF);
    chk("abort_pass", PASS, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    run(0, 0, 1'b1, 8'h00, 4'hF, 1 + NV * 5, 0);

    run(0, 1, 1'b0, 8'h08, 4'h1, 1 + NV * 5, 1);
`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_BIST_WALK_EN
    run(0, 3, 1'b0, 8'h24, 4'h6, 1 + NV * 5, 0);
`endif
    chk("queue_drained", q1.size() + q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
